// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser and glitch filter, 11-bit frame decoder, byte FIFO.
// Optional PS2_RX_ERR_COUNT_EN enables the saturating err_count; otherwise err_count is tied to zero.
module ps2_rx_fifo #(
  parameter int unsigned SYSTEM_CLOCK = 25_000_000,
  parameter int unsigned PS2_CLOCK    = 10_000,
  parameter int unsigned TIMEOUT_BITS = 2,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_overflow,
  output logic [7:0] err_count
);

  localparam int unsigned T_CYC = TIMEOUT_BITS * SYSTEM_CLOCK / PS2_CLOCK;
  localparam int unsigned TW    = $clog2(T_CYC + 1);
  localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // index 0 = clock line, index 1 = data line
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_prev;
  logic          fall, bit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {ps2_data, ps2_clk};
      sync2 <= sync1;
    end
  end

  // Filtered line flips only after FILTER_LEN consecutive samples disagreeing with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt    <= '1;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= filt[0];
  end

  assign fall   = clk_prev & ~filt[0];
  assign bit_in = filt[1];

  state_t        state, state_nx;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          push, perr_nx, ferr_nx, ovf_nx;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    perr_nx  = 1'b0;
    ferr_nx  = 1'b0;
    if (state != S_IDLE && !fall && to_cnt == TW'(T_CYC)) begin
      ferr_nx  = 1'b1;
      state_nx = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!bit_in) state_nx = S_DATA;
        S_DATA:   if (bitcnt == 3'd7) state_nx = S_PARITY;
        S_PARITY: state_nx = S_STOP;
        S_STOP: begin
          state_nx = S_IDLE;
          if (!(^shreg ^ par_bit)) perr_nx = 1'b1;
          else if (!bit_in)        ferr_nx = 1'b1;
          else                     push    = 1'b1;
        end
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bitcnt  <= '0;
      par_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        S_IDLE:   bitcnt <= '0;
        S_DATA: begin
          shreg  <= {bit_in, shreg[7:1]};
          bitcnt <= bitcnt + 1'b1;
        end
        S_PARITY: par_bit <= bit_in;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE || fall) to_cnt <= '0;
    else if (to_cnt != TW'(T_CYC))        to_cnt <= to_cnt + 1'b1;
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, full, do_write;

  assign pop      = rx_valid & rx_ready;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_write = push & (~full | pop);
  assign ovf_nx   = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      parity_err  <= perr_nx;
      frame_err   <= ferr_nx;
      rx_overflow <= ovf_nx;
    end
  end

`ifdef PS2_RX_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) err_count <= '0;
    else if ((parity_err | frame_err | rx_overflow) && err_count != 8'hFF)
      err_count <= err_count + 1'b1;
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: 40 clk per PS/2 bit, timeout 80 clk, FILTER_LEN 4, FIFO_DEPTH 4.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data, err_count;
  logic       parity_err, frame_err, rx_overflow;

  int total = 0;
  int bad   = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0, n_wide = 0;
  logic pe_q = 1'b0, fe_q = 1'b0, ov_q = 1'b0;

  ps2_rx_fifo #(
    .SYSTEM_CLOCK(400_000),
    .PS2_CLOCK(10_000),
    .TIMEOUT_BITS(2),
    .FILTER_LEN(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .rx_overflow(rx_overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Tally error pulses and flag any pulse lasting more than one cycle.
  always @(posedge clk) begin
    if (!reset) begin
      n_perr <= n_perr + int'(parity_err);
      n_ferr <= n_ferr + int'(frame_err);
      n_ovf  <= n_ovf + int'(rx_overflow);
      if ((parity_err && pe_q) || (frame_err && fe_q) || (rx_overflow && ov_q))
        n_wide <= n_wide + 1;
    end
    pe_q <= parity_err;
    fe_q <= frame_err;
    ov_q <= rx_overflow;
  end

  initial begin
    #1ms;
    $error("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    wait_neg(4);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_neg(3);
      ps2_clk = 1'b1;
    end
    wait_neg(6);
    ps2_clk = 1'b0;
    wait_neg(20);
    ps2_clk = 1'b1;
    wait_neg(10);
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) send_bit(fr[i], i == glitch_bit);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  initial begin
    int p0, f0, o0;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rx_ready = 1'b0;
    wait_neg(5);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(rx_overflow), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    reset = 1'b0;
    wait_neg(10);

    // 0x1C, exact latency from the stop-bit pin fall: sync 2 + filter 4, push 1 later
    p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 10, -1);
    ps2_data = 1'b1;
    wait_neg(10);
    ps2_clk = 1'b0;
    wait_neg(6);
    check("1c_valid_early", 32'(rx_valid), 32'd0);
    wait_neg(1);
    check("1c_valid", 32'(rx_valid), 32'd1);
    check("1c_data", 32'(rx_data), 32'h1C);
    wait_neg(13);
    ps2_clk = 1'b1;
    wait_neg(10);
    check("1c_no_err", 32'(n_perr - p0 + n_ferr - f0 + n_ovf - o0), 32'd0);
    rx_ready = 1'b1;
    wait_neg(1);
    check("1c_popped", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // 0xF0 with wrong parity
    p0 = n_perr; f0 = n_ferr;
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11, -1);
    wait_neg(20);
    check("f0_perr", 32'(n_perr - p0), 32'd1);
    check("f0_no_ferr", 32'(n_ferr - f0), 32'd0);
    check("f0_valid", 32'(rx_valid), 32'd0);
`ifdef PS2_RX_ERR_COUNT_EN
    check("f0_errcnt", 32'(err_count), 32'd1);
`else
    check("f0_errcnt", 32'(err_count), 32'd0);
`endif

    // 0x1C with stop bit 0
    p0 = n_perr; f0 = n_ferr;
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11, -1);
    ps2_data = 1'b1;
    wait_neg(20);
    check("stop0_ferr", 32'(n_ferr - f0), 32'd1);
    check("stop0_no_perr", 32'(n_perr - p0), 32'd0);
    check("stop0_valid", 32'(rx_valid), 32'd0);

    // partial frame then bus idle beyond the timeout
    f0 = n_ferr;
    send_bits(mk(8'hA5, 1'b0, 1'b1), 4, -1);
    ps2_data = 1'b1;
    wait_neg(30);
    check("to_not_yet", 32'(n_ferr - f0), 32'd0);
    wait_neg(60);
    check("to_ferr", 32'(n_ferr - f0), 32'd1);
    check("to_valid", 32'(rx_valid), 32'd0);
    send_bits(mk(8'h5A, odd_par(8'h5A), 1'b1), 11, -1);
    wait_neg(20);
    check("5a_valid", 32'(rx_valid), 32'd1);
    check("5a_data", 32'(rx_data), 32'h5A);
    rx_ready = 1'b1;
    wait_neg(1);
    rx_ready = 1'b0;
    check("5a_popped", 32'(rx_valid), 32'd0);

    // fill FIFO with 0x01..0x04, 0x05 overflows
    o0 = n_ovf;
    for (int i = 1; i <= 4; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_bits(mk(b, odd_par(b), 1'b1), 11, -1);
    end
    wait_neg(20);
    check("fill_no_ovf", 32'(n_ovf - o0), 32'd0);
    send_bits(mk(8'h05, odd_par(8'h05), 1'b1), 11, -1);
    wait_neg(20);
    check("fill_ovf", 32'(n_ovf - o0), 32'd1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(rx_valid), 32'd1);
      check("drain_data", 32'(rx_data), 32'(i));
      wait_neg(1);
    end
    check("drain_empty", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
`ifdef PS2_RX_ERR_COUNT_EN
    check("errcnt_total", 32'(err_count), 32'd4);
`else
    check("errcnt_total", 32'(err_count), 32'd0);
`endif

    // 3-cycle clock glitch during data bit 3 must be filtered out
    p0 = n_perr; f0 = n_ferr;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11, 4);
    wait_neg(20);
    check("glitch_valid", 32'(rx_valid), 32'd1);
    check("glitch_data", 32'(rx_data), 32'h1C);
    check("glitch_no_err", 32'(n_perr - p0 + n_ferr - f0), 32'd0);
    check("pulse_width", 32'(n_wide), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
